// File: rtl/adam_pause_seq.sv
// adam_pause_seq: fans one upstream 4-phase pause handshake out to NO_TGTS
// downstream pause handshakes. Targets pause in ascending index order and
// resume in descending order. Only one target handshake is open at a time,
// so tgt_pause_req is always a thermometer code.
//
// Optional feature: define ADAM_PAUSE_SEQ_TIMEOUT_EN to build the per-step
// wait counter and the sticky timeout flag. Without it, timeout is tied to 0.
//
// Handshake rules, upstream and per target: req is a level. The receiver
// answers by driving ack to the same level. req changes only when ack
// already matches it, and it then holds until ack matches the new level.
module adam_pause_seq #(
    parameter  int NO_TGTS     = 4,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int IDX_W       = (NO_TGTS > 1) ? $clog2(NO_TGTS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pause_req,
    output logic               pause_ack,
    output logic [NO_TGTS-1:0] tgt_pause_req,
    input  logic [NO_TGTS-1:0] tgt_pause_ack,
    output logic               busy,
    output logic [IDX_W-1:0]   cur_idx,
    output logic               timeout,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        PAUSING  = 2'd1,
        PAUSED   = 2'd2,
        RESUMING = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NO_TGTS - 1);

    state_t             state_q, state_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic [NO_TGTS-1:0] req_q, req_n;
    logic               ack_q, ack_n;
    logic               busy_q, busy_n;
    logic               step_start;
    logic [IDX_W-1:0]   idx_inc, idx_dec;
    logic               ack_cur;

    assign idx_inc = idx_q + 1'b1;
    assign idx_dec = idx_q - 1'b1;
    assign ack_cur = tgt_pause_ack[idx_q];

    // State, index, request vector and handshake outputs are all registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            idx_q   <= '0;
            req_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            req_q   <= req_n;
            ack_q   <= ack_n;
            busy_q  <= busy_n;
        end
    end

    // Next-state logic. A step completes only when the ack of the current
    // target matches its req, so a target handshake is never cut short.
    // Acks of the other targets are never looked at.
    always_comb begin
        state_n    = state_q;
        idx_n      = idx_q;
        req_n      = req_q;
        step_start = 1'b0;
        case (state_q)
            RUN: begin
                if (pause_req) begin
                    state_n    = PAUSING;
                    idx_n      = '0;
                    req_n[0]   = 1'b1;
                    step_start = 1'b1;
                end
            end
            PAUSING: begin
                if (ack_cur) begin
                    step_start = 1'b1;
                    if (!pause_req) begin
                        // Aborted pause: unwind only the targets 0..idx.
                        state_n       = RESUMING;
                        req_n[idx_q]  = 1'b0;
                    end else if (idx_q == LAST_IDX) begin
                        state_n = PAUSED;
                    end else if (req_q[idx_inc]) begin
                        // Upper targets never resumed; skip straight to PAUSED.
                        state_n = PAUSED;
                        idx_n   = LAST_IDX;
                    end else begin
                        idx_n          = idx_inc;
                        req_n[idx_inc] = 1'b1;
                    end
                end
            end
            PAUSED: begin
                if (!pause_req) begin
                    state_n         = RESUMING;
                    idx_n           = LAST_IDX;
                    req_n[LAST_IDX] = 1'b0;
                    step_start      = 1'b1;
                end
            end
            RESUMING: begin
                if (!ack_cur) begin
                    step_start = 1'b1;
                    if (pause_req) begin
                        // Aborted resume: re-pause from the target just resumed.
                        state_n      = PAUSING;
                        req_n[idx_q] = 1'b1;
                    end else if (idx_q == '0) begin
                        state_n = RUN;
                    end else begin
                        idx_n          = idx_dec;
                        req_n[idx_dec] = 1'b0;
                    end
                end
            end
            default: begin
                state_n = RUN;
                idx_n   = '0;
                req_n   = '0;
            end
        endcase
    end

    // Registered-output values derived from the next state.
    always_comb begin
        ack_n  = (state_n == PAUSED);
        busy_n = (state_n == PAUSING) || (state_n == RESUMING);
    end

`ifdef ADAM_PAUSE_SEQ_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    // Per-step wait counter, saturating; timeout latches when it saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else if (step_start || !busy_q) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    wire unused_step_start = step_start;
    assign timeout = 1'b0;
`endif

    assign pause_ack     = ack_q;
    assign tgt_pause_req = req_q;
    assign busy          = busy_q;
    assign cur_idx       = idx_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_adam_pause_seq.sv
// Directed bench for adam_pause_seq with NO_TGTS=3, TIMEOUT_CYC=8.
// Each target is modelled as acking its req two clocks later.
// The observed word is {tgt_pause_req[2:0], pause_ack, busy, cur_idx[1:0], timeout}.
module tb_adam_pause_seq;

    localparam int N  = 3;
    localparam int TO = 8;
`ifdef ADAM_PAUSE_SEQ_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    typedef struct {
        logic       preq;
        int         ncyc;
        logic [7:0] exp;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         pause_req;
    logic         pause_ack;
    logic [N-1:0] tgt_pause_req;
    logic [N-1:0] tgt_pause_ack;
    logic         busy;
    logic [1:0]   cur_idx;
    logic         timeout;
    logic [1:0]   state_dbg;

    logic [N-1:0] ack_d1, ack_d2, hold_low, tog;
    logic         mon_en, mon_seen;

    int           errors = 0;
    int           checks = 0;
    logic [7:0]   exp_q[$];
    vec_t         vt[13];

    adam_pause_seq #(.NO_TGTS(N), .TIMEOUT_CYC(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .pause_req     (pause_req),
        .pause_ack     (pause_ack),
        .tgt_pause_req (tgt_pause_req),
        .tgt_pause_ack (tgt_pause_ack),
        .busy          (busy),
        .cur_idx       (cur_idx),
        .timeout       (timeout),
        .state_dbg     (state_dbg)
    );

    // clock / reset-independent clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Target model: ack follows req two clocks later; hold_low and tog
    // let the test freeze or glitch individual acks.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_d1 <= '0;
            ack_d2 <= '0;
        end else begin
            ack_d1 <= tgt_pause_req;
            ack_d2 <= ack_d1;
        end
    end
    assign tgt_pause_ack = (ack_d2 & ~hold_low) ^ tog;

    // Watch for req[2] or pause_ack during the aborted-pause sequence.
    always @(negedge clk) begin
        if (mon_en && (tgt_pause_req[2] || pause_ack)) mon_seen <= 1'b1;
    end

    function automatic logic [7:0] ev(input logic [2:0] r, input logic pa,
                                      input logic b, input logic [1:0] i,
                                      input logic t);
        return {r, pa, b, i, t};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = {tgt_pause_req, pause_ack, busy, cur_idx, timeout};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got req/ack/busy/idx/to=%b required %b", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    initial begin
        // Full pause then full resume, timeline relative to the first sample edge.
        vt[0]  = '{1'b1, 1, ev(3'b001, 0, 1, 2'd0, 0)};
        vt[1]  = '{1'b1, 2, ev(3'b001, 0, 1, 2'd0, 0)};
        vt[2]  = '{1'b1, 1, ev(3'b011, 0, 1, 2'd1, 0)};
        vt[3]  = '{1'b1, 3, ev(3'b111, 0, 1, 2'd2, 0)};
        vt[4]  = '{1'b1, 2, ev(3'b111, 0, 1, 2'd2, 0)};
        vt[5]  = '{1'b1, 1, ev(3'b111, 1, 0, 2'd2, 0)};
        vt[6]  = '{1'b1, 2, ev(3'b111, 1, 0, 2'd2, 0)};
        vt[7]  = '{1'b0, 1, ev(3'b011, 0, 1, 2'd2, 0)};
        vt[8]  = '{1'b0, 3, ev(3'b001, 0, 1, 2'd1, 0)};
        vt[9]  = '{1'b0, 3, ev(3'b000, 0, 1, 2'd0, 0)};
        vt[10] = '{1'b0, 2, ev(3'b000, 0, 1, 2'd0, 0)};
        vt[11] = '{1'b0, 1, ev(3'b000, 0, 0, 2'd0, 0)};
        vt[12] = '{1'b0, 3, ev(3'b000, 0, 0, 2'd0, 0)};

        rst       = 1'b0;
        pause_req = 1'b0;
        hold_low  = '0;
        tog       = '0;
        mon_en    = 1'b0;
        mon_seen  = 1'b0;
        #1;
        check("reset_state", ev(3'b000, 0, 0, 2'd0, 0));
        step(3);
        rst = 1'b1;
        step(2);
        check("after_reset_idle", ev(3'b000, 0, 0, 2'd0, 0));
        check_bit("state_run", state_dbg == 2'd0, 1'b1);

        // Table: pause 3 targets then resume.
        foreach (vt[k]) exp_q.push_back(vt[k].exp);
        for (int k = 0; k < 13; k++) begin
            pause_req = vt[k].preq;
            step(vt[k].ncyc);
            check($sformatf("table_row_%0d", k), exp_q.pop_front());
        end

        // Pause aborted at idx 1: only targets 1 and 0 unwind.
        mon_en    = 1'b1;
        pause_req = 1'b1;
        step(4);
        check("abort_pause_idx1", ev(3'b011, 0, 1, 2'd1, 0));
        pause_req = 1'b0;
        step(3);
        check("abort_step1_done", ev(3'b001, 0, 1, 2'd1, 0));
        step(3);
        check("abort_bit0_clear", ev(3'b000, 0, 1, 2'd0, 0));
        step(3);
        check("abort_back_run", ev(3'b000, 0, 0, 2'd0, 0));
        mon_en = 1'b0;
        check_bit("abort_no_req2_no_ack", mon_seen, 1'b0);

        // Resume aborted at idx 1: target 1 re-paused, then 2.
        pause_req = 1'b1;
        step(10);
        check("repause_paused", ev(3'b111, 1, 0, 2'd2, 0));
        pause_req = 1'b0;
        step(1);
        check("repause_resume2", ev(3'b011, 0, 1, 2'd2, 0));
        step(3);
        check("repause_resume1", ev(3'b001, 0, 1, 2'd1, 0));
        pause_req = 1'b1;
        step(3);
        check("repause_req1_set", ev(3'b011, 0, 1, 2'd1, 0));
        step(3);
        check("repause_req2_set", ev(3'b111, 0, 1, 2'd2, 0));
        step(3);
        check("repause_ack_back", ev(3'b111, 1, 0, 2'd2, 0));
        pause_req = 1'b0;
        step(10);
        check("repause_to_run", ev(3'b000, 0, 0, 2'd0, 0));

        // Stray ack on an idle target is ignored.
        tog = 3'b100;
        step(2);
        tog = 3'b010;
        step(1);
        tog = '0;
        check("stray_ack_ignored", ev(3'b000, 0, 0, 2'd0, 0));

        // Ack 1 held low: timeout at the 8th waiting cycle, sequence still completes.
        hold_low  = 3'b010;
        pause_req = 1'b1;
        step(4);
        check("hold_step1_entry", ev(3'b011, 0, 1, 2'd1, 0));
        step(7);
        check("hold_7_waits", ev(3'b011, 0, 1, 2'd1, 0));
        step(1);
        check("hold_8_waits", ev(3'b011, 0, 1, 2'd1, TO_EN));
        hold_low = '0;
        step(1);
        check("hold_released", ev(3'b111, 0, 1, 2'd2, TO_EN));
        step(3);
        check("hold_paused_sticky", ev(3'b111, 1, 0, 2'd2, TO_EN));

        // Asynchronous reset in the middle of a resume.
        pause_req = 1'b0;
        step(1);
        check("pre_reset_resume", ev(3'b011, 0, 1, 2'd2, TO_EN));
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_clear", ev(3'b000, 0, 0, 2'd0, 0));
        step(2);
        rst = 1'b1;
        step(3);
        check("post_reset_idle", ev(3'b000, 0, 0, 2'd0, 0));
        pause_req = 1'b1;
        step(1);
        check("post_reset_pause", ev(3'b001, 0, 1, 2'd0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
